// File: rtl/riscv_uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_uart_pkg
// Description : Shared encodings, FSM state type and divisor helpers for the
//               risc_v_uart echo node.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_uart_pkg;

  // Baud-rate select encodings
  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  // Parity select encodings (2'b11 also means no parity)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Common state set for the receive and transmit sequencers
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clocks per bit for a baud select; each branch divides constants only,
  // so no run-time divider is built.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [1:0]  sel);
    int unsigned d;
    case (sel)
      BAUD_2400: d = clk_freq / 2400;
      BAUD_4800: d = clk_freq / 4800;
      BAUD_9600: d = clk_freq / 9600;
      default:   d = clk_freq / 19200;
    endcase
    return d;
  endfunction

  // True when the parity select carries a parity bit
  function automatic logic parity_on(input logic [1:0] pt);
    return (pt == PAR_ODD) || (pt == PAR_EVEN);
  endfunction

  // Parity bit that makes the data+parity ones count obey the selected rule
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] pt);
    return (pt == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_v_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Serialiser for the echo path: start bit, 8 data bits LSB
//               first, optional parity, one stop bit, each held div clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import riscv_uart_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    data_i,
  input  logic [CW-1:0] div_i,
  input  logic [1:0]    parity_i,
  output logic          ready_o,
  output logic          tx_o
);

  uart_state_e   state_q;
  logic          tx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] div_q;
  logic [2:0]    idx_q;
  logic [7:0]    byte_q;
  logic [7:0]    shift_q;
  logic [1:0]    par_q;
  logic          w_bit_end;

  assign w_bit_end = (cnt_q == div_q - CW'(1));
  assign ready_o   = (state_q == ST_IDLE);
  assign tx_o      = tx_q;

  // Frame sequencer; the line level is registered and changes only on bit boundaries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      par_q   <= PAR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (start_i) begin
            // Rate and parity are frozen for the whole frame here
            byte_q  <= data_i;
            shift_q <= data_i;
            div_q   <= div_i;
            par_q   <= parity_i;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              if (parity_on(par_q)) begin
                tx_q    <= parity_bit(byte_q, par_q);
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/risc_v_uart.sv
`default_nettype none
// ============================================================================
// Module      : risc_v_uart
// Description : UART echo node. Receives async frames on data_rx, publishes
//               each good byte on data_out and echoes it on data_tx through
//               a one-byte holding register (newest byte wins).
// Revision    : 1.0 - initial release
// ============================================================================
module risc_v_uart
  import riscv_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clkI,
  input  logic       reset,
  input  logic       data_rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic       data_tx,
  output logic [7:0] data_out
);

  // Counters are sized for the slowest rate so they never wrap
  localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, BAUD_2400);
  localparam int unsigned CW      = $clog2(DIV_MAX + 1);

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          w_rx, w_fall;
  uart_state_e   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [CW-1:0] rx_div_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic [1:0]    rx_par_q;
  logic          rx_par_bit_q;
  logic          wait_high_q;
  logic          rx_valid_q;
  logic [7:0]    data_out_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;
  logic [CW-1:0] w_div_sel;
  logic          w_rx_bit_end, w_rx_half_end, w_par_ok;
  logic          w_tx_ready, w_tx_start;
  logic [7:0]    w_tx_data;

  assign w_rx          = rx_s2_q;
  assign w_fall        = rx_prev_q & ~rx_s2_q;
  assign w_div_sel     = CW'(baud_div(CLK_FREQ, baud_rate));
  assign w_rx_bit_end  = (rx_cnt_q == rx_div_q - CW'(1));
  assign w_rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - CW'(1));
  assign w_par_ok      = !parity_on(rx_par_q) ||
                         (rx_par_bit_q == parity_bit(rx_shift_q, rx_par_q));
  assign data_out      = data_out_q;

  // Two-flop synchroniser plus one delayed copy for start-edge detection
  always_ff @(posedge clkI or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= data_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receive sequencer: half-bit start check, then mid-bit sampling every div clocks
  always_ff @(posedge clkI or posedge reset) begin
    if (reset) begin
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= PAR_NONE;
      rx_par_bit_q <= 1'b0;
      wait_high_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      data_out_q   <= 8'h00;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        ST_IDLE: begin
          rx_cnt_q <= '0;
          if (wait_high_q) begin
            // After a framing error the line must go idle before re-arming
            if (w_rx) wait_high_q <= 1'b0;
          end else if (w_fall) begin
            rx_div_q   <= w_div_sel;
            rx_par_q   <= parity_type;
            rx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (w_rx_half_end) begin
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            // A line already high again at mid-start is a glitch
            rx_state_q <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {w_rx, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) begin
              rx_state_q <= parity_on(rx_par_q) ? ST_PARITY : ST_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        ST_PARITY: begin
          if (w_rx_bit_end) begin
            rx_cnt_q     <= '0;
            rx_par_bit_q <= w_rx;
            rx_state_q   <= ST_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_IDLE;
            if (w_rx && w_par_ok) begin
              data_out_q <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else if (!w_rx) begin
              wait_high_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  // A fresh byte goes straight to an idle transmitter; otherwise the held byte goes first
  assign w_tx_start = w_tx_ready & (hold_full_q | rx_valid_q);
  assign w_tx_data  = hold_full_q ? hold_q : data_out_q;

  // Holding register: parks a byte while TX is busy, newest byte overwrites
  always_ff @(posedge clkI or posedge reset) begin
    if (reset) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (rx_valid_q && (!w_tx_ready || hold_full_q)) begin
      hold_q      <= data_out_q;
      hold_full_q <= 1'b1;
    end else if (w_tx_start && hold_full_q) begin
      hold_full_q <= 1'b0;
    end
  end

  uart_tx #(
    .CW (CW)
  ) u_tx (
    .clk_i    (clkI),
    .rst_i    (reset),
    .start_i  (w_tx_start),
    .data_i   (w_tx_data),
    .div_i    (w_div_sel),
    .parity_i (parity_type),
    .ready_o  (w_tx_ready),
    .tx_o     (data_tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_risc_v_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_v_uart
// Description : Self-checking bench for risc_v_uart: serial stimulus, a
//               byte-level echo model feeding a queue, and a data_tx decoder
//               that pops and compares every transmitted frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_v_uart;

  localparam int unsigned CLK_FREQ = 1_920_000;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
  } echo_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [1:0] baud = 2'b11;
  logic [1:0] par  = 2'b00;
  logic       tx;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  echo_t      exp_q[$];
  logic [7:0] mdl_last = 8'h00;
  bit         mdl_pend = 1'b0;
  logic [7:0] mdl_pend_byte = 8'h00;
  int         mdl_busy_until = 0;

  risc_v_uart #(.CLK_FREQ(CLK_FREQ)) dut (
    .clkI        (clk),
    .reset       (rst),
    .data_rx     (rx),
    .baud_rate   (baud),
    .parity_type (par),
    .data_tx     (tx),
    .data_out    (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input logic [1:0] b);
    case (b)
      2'b00:   return int'(CLK_FREQ / 2400);
      2'b01:   return int'(CLK_FREQ / 4800);
      2'b10:   return int'(CLK_FREQ / 9600);
      default: return int'(CLK_FREQ / 19200);
    endcase
  endfunction

  function automatic bit par_en(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic logic par_for(input logic [7:0] d, input logic [1:0] p);
    int ones;
    ones = $countones(d);
    if (p == 2'b01) return ((ones % 2) == 0);
    return ((ones % 2) == 1);
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic [1:0] p);
    logic [10:0] f;
    f = '0;
    f[8:1] = d;
    if (par_en(p)) begin
      f[9]  = par_for(d, p);
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Echo model: a byte arriving while an echo is on the wire waits in one slot
  task automatic mdl_launch(input logic [7:0] d);
    exp_q.push_back('{data: d, div: 16'(div_of(baud)), par: par});
    mdl_busy_until = cyc + (par_en(par) ? 11 : 10) * div_of(baud) + 1;
  endtask

  task automatic mdl_good(input logic [7:0] d);
    mdl_last = d;
    if (cyc < mdl_busy_until) begin
      mdl_pend      = 1'b1;
      mdl_pend_byte = d;
    end else begin
      mdl_launch(d);
    end
  endtask

  task automatic mdl_reset();
    exp_q.delete();
    mdl_last       = 8'h00;
    mdl_pend       = 1'b0;
    mdl_busy_until = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && mdl_pend && cyc >= mdl_busy_until) begin
      mdl_pend = 1'b0;
      mdl_launch(mdl_pend_byte);
    end
  end

  // Drive one frame; the model learns of a good byte at the stop-bit middle
  task automatic send_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                            input bit bad_par, input bit stop_bit);
    int dv;
    dv = div_of(b);
    baud = b;
    par  = p;
    @(negedge clk);
    rx = 1'b0;
    repeat (dv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (dv) @(negedge clk);
    end
    if (par_en(p)) begin
      rx = par_for(d, p) ^ bad_par;
      repeat (dv) @(negedge clk);
    end
    rx = stop_bit;
    repeat (dv / 2) @(negedge clk);
    if (stop_bit && !(par_en(p) && bad_par)) mdl_good(d);
    repeat (dv - dv / 2) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("data_out_after_frame", {24'h0, dout}, {24'h0, mdl_last});
  endtask

  // data_tx decoder: checks every bit at its first, middle and last clock
  initial begin
    echo_t       ent;
    logic [10:0] expb, gotb;
    int          e, n, dv, k, r;
    bit          bad, aborted;
    forever begin
      @(negedge clk);
      if (rst || tx !== 1'b0) continue;
      e = 0;
      while (exp_q.size() == 0 && e < 50 && !rst) begin
        @(negedge clk);
        e++;
      end
      if (rst) continue;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected_frame: got start bit expected idle line (cycle %0d)", cyc);
        for (int i = 0; i < 20000 && tx !== 1'b1; i++) @(negedge clk);
        continue;
      end
      ent  = exp_q[0];
      dv   = int'(ent.div);
      n    = par_en(ent.par) ? 11 : 10;
      expb = frame_bits(ent.data, ent.par);
      gotb = '0;
      bad  = 1'b0;
      aborted = 1'b0;
      for (int c = e; c < n * dv; c++) begin
        if (c != e) @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        k = c / dv;
        r = c % dv;
        if (r == dv / 2) gotb[k] = tx;
        if ((r == 0 || r == dv / 2 || r == dv - 1) && tx !== expb[k]) bad = 1'b1;
      end
      if (aborted) continue;
      void'(exp_q.pop_front());
      checks++;
      if (bad || gotb !== expb) begin
        errors++;
        $display("FAIL tx_frame: got bits %b expected %b (byte %0h, timing ok=%0d)",
                 gotb, expb, ent.data, !bad);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         lat;
    bit         seen;
    logic [7:0] prev;
    logic [7:0] rb;
    logic [1:0] rbaud, rpar;
    int         fault;

    // Reset held: line idle, data_out cleared, no echo activity
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || dout !== 8'h00) ok = 1'b0;
    end
    check("reset_hold_idle", ok, 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_tx", tx, 1);
    check("post_reset_dout", dout, 0);

    // Even parity A5, with echo start latency measured from data_out update
    prev = dout;
    lat  = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5, 2'b11, 2'b10, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 3000 && !seen; i++) begin
          @(negedge clk);
          if (dout !== prev) seen = 1'b1;
        end
        while (seen && tx !== 1'b0 && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        check("echo_start_latency", (seen && lat >= 1 && lat <= 2), 1);
      end
    join
    repeat (1300) @(negedge clk);

    // Odd parity 3C with the parity bit wrong: dropped, no echo
    send_frame(8'h3C, 2'b11, 2'b01, 1'b1, 1'b1);
    repeat (1300) @(negedge clk);

    // Framing error on 55, then 81 once the line is idle again
    send_frame(8'h55, 2'b11, 2'b00, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    send_frame(8'h81, 2'b11, 2'b00, 1'b0, 1'b1);
    repeat (1300) @(negedge clk);

    // Short low pulse shorter than half a bit is a glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (div_of(2'b11) / 2 - 15) @(negedge clk);
    rx = 1'b1;
    repeat (2 * div_of(2'b11)) @(negedge clk);
    check("glitch_no_byte", dout, 8'h81);
    send_frame(8'h5A, 2'b11, 2'b11, 1'b0, 1'b1);
    repeat (1300) @(negedge clk);

    // Randomised frames with random rate, parity mode and fault injection
    for (int f = 0; f < 6; f++) begin
      rb    = 8'($urandom_range(0, 255));
      rbaud = 2'($urandom_range(2, 3));
      rpar  = 2'($urandom_range(0, 3));
      fault = int'($urandom_range(0, 3));
      send_frame(rb, rbaud, rpar, fault == 2, fault != 3);
      repeat (13 * div_of(rbaud) + 100) @(negedge clk);
    end
    check("echo_queue_drained", exp_q.size(), 0);

    // Slow frame 11 echoes slowly; 22 and 33 arrive meanwhile, 33 wins
    send_frame(8'h11, 2'b00, 2'b00, 1'b0, 1'b1);
    send_frame(8'h22, 2'b11, 2'b00, 1'b0, 1'b1);
    send_frame(8'h33, 2'b11, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 12000 && mdl_pend; i++) @(negedge clk);
    for (int i = 0; i < 60 && tx !== 1'b0; i++) @(negedge clk);
    check("held_byte_tx_started", tx, 0);
    repeat (300) @(negedge clk);

    // Reset in the middle of the echo frame
    #1 rst = 1'b1;
    mdl_reset();
    #1;
    check("reset_mid_tx_line", tx, 1);
    check("reset_mid_tx_dout", dout, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || dout !== 8'h00) ok = 1'b0;
    end
    check("idle_after_reset", ok, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
